// File: rtl/fifo_seq_ctrl_pkg.sv
// Shared definitions for the FIFO sequencer: state encodings, widths and helpers.
package fifo_seq_ctrl_pkg;

    localparam int ST_W  = 3;
    localparam int CNT_W = 16;

    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_FILL     = 3'd1;
    localparam logic [ST_W-1:0] ST_F_SETTLE = 3'd2;
    localparam logic [ST_W-1:0] ST_DRAIN    = 3'd3;
    localparam logic [ST_W-1:0] ST_D_SETTLE = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE     = 3'd5;

    // Debug counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_seq_ctrl_flag_sync.sv
// Shift-register synchronizer for one FIFO status flag.
module fifo_seq_ctrl_flag_sync #(
    parameter int STAGES = 3
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic flag_raw,
    output logic flag_syn
);

    logic [STAGES-1:0] shreg;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            shreg <= '0;
        end else begin
            shreg <= {shreg[STAGES-2:0], flag_raw};
        end
    end

    assign flag_syn = shreg[STAGES-1];

endmodule

// File: rtl/fifo_seq_ctrl.sv
// Fill/drain sequencer for one FIFO: writes an incrementing pattern, reads it back
// and counts mismatches, for a configurable number of passes.
module fifo_seq_ctrl
    import fifo_seq_ctrl_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 3,
    parameter int SETTLE_CYC  = 10,
    parameter int PASSES      = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_full,
    input  logic              almost_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    input  logic              almost_empty,
    output logic              busy,
    output logic [ST_W-1:0]   state,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic              af_syn;
    logic              ae_syn;
    logic [DATA_W-1:0] wr_cnt;
    logic [DATA_W-1:0] exp_cnt;
    logic [CNT_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  pass_next;
    logic              settle_done;
    logic              rd_vld;
    logic              start_acc;

    fifo_seq_ctrl_flag_sync #(.STAGES(SYNC_STAGES)) u_af_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .flag_raw  (almost_full),
        .flag_syn  (af_syn)
    );

    fifo_seq_ctrl_flag_sync #(.STAGES(SYNC_STAGES)) u_ae_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .flag_raw  (almost_empty),
        .flag_syn  (ae_syn)
    );

    assign busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign start_acc   = start && !busy;
    assign settle_done = (settle_cnt == CNT_W'(SETTLE_CYC - 1));
    assign pass_next   = pass_cnt + 1'b1;

    // Raw full/empty gates cover the cycles where the synchronized flags still lag.
    assign fifo_wr_en   = sys_rst_n && (state == ST_FILL)  && !af_syn && !fifo_full;
    assign fifo_rd_en   = sys_rst_n && (state == ST_DRAIN) && !ae_syn && !fifo_empty;
    assign fifo_wr_data = wr_cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            pass_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_FILL;
                        pass_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (af_syn) begin
                        state      <= ST_F_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_F_SETTLE: begin
                    if (settle_done) begin
                        state <= ST_DRAIN;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ae_syn) begin
                        state      <= ST_D_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_D_SETTLE: begin
                    if (settle_done) begin
                        pass_cnt <= pass_next;
                        if ((PASSES != 0) && (pass_next == CNT_W'(PASSES))) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_FILL;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data counters survive start so leftover FIFO words stay in sequence across sessions.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_cnt  <= '0;
            exp_cnt <= '0;
            rd_vld  <= 1'b0;
            err_cnt <= '0;
        end else begin
            rd_vld <= fifo_rd_en;
            if (fifo_wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (rd_vld) begin
                exp_cnt <= exp_cnt + 1'b1;
            end
            if (start_acc) begin
                err_cnt <= '0;
            end else if (rd_vld && (fifo_rd_data != exp_cnt)) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Directed bench for fifo_seq_ctrl with a behavioural 256-deep FIFO beside it.
module tb_fifo_seq_ctrl;

    localparam int DEPTH = 256;
    localparam int AF_TH = 250;
    localparam int AE_TH = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        force_full = 1'b0;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        almost_full;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic        almost_empty;
    logic        busy;
    logic [2:0]  state;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  wp = 8'd0;
    logic [7:0]  rp = 8'd0;
    logic [7:0]  rd_q = 8'd0;
    logic [7:0]  wr_model = 8'd0;
    int          count = 0;
    int          read_total = 0;
    int          corrupt_idx = -1;
    int          wr_seq_err = 0;
    logic        overflow_seen = 1'b0;
    logic        underflow_seen = 1'b0;
    logic        both_seen = 1'b0;
    logic        do_wr;
    logic        do_rd;

    int n_checks = 0;
    int n_fail = 0;

    fifo_seq_ctrl #(
        .DATA_W      (8),
        .SYNC_STAGES (3),
        .SETTLE_CYC  (10),
        .PASSES      (2)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .almost_empty (almost_empty),
        .busy         (busy),
        .state        (state),
        .pass_cnt     (pass_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    assign fifo_full    = (count >= DEPTH) || force_full;
    assign fifo_empty   = (count == 0);
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);
    assign fifo_rd_data = rd_q;
    assign do_wr        = (fifo_wr_en === 1'b1) && !fifo_full;
    assign do_rd        = (fifo_rd_en === 1'b1) && !fifo_empty;

    // Behavioural FIFO plus protocol and write-sequence monitor.
    always @(posedge sys_clk) begin
        if (fifo_wr_en === 1'b1) begin
            if (fifo_full) overflow_seen <= 1'b1;
            if (fifo_rd_en === 1'b1) both_seen <= 1'b1;
            if (fifo_wr_data !== wr_model) wr_seq_err <= wr_seq_err + 1;
            wr_model <= wr_model + 8'd1;
        end
        if ((fifo_rd_en === 1'b1) && fifo_empty) underflow_seen <= 1'b1;
        if (do_wr) begin
            mem[wp] <= fifo_wr_data;
            wp      <= wp + 8'd1;
        end
        if (do_rd) begin
            rd_q       <= mem[rp] ^ ((read_total == corrupt_idx) ? 8'h01 : 8'h00);
            rp         <= rp + 8'd1;
            read_total <= read_total + 1;
        end
        count <= count + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
    end

    task automatic applyStimulus(input logic rst_v, input logic start_v, input logic ff_v);
        @(posedge sys_clk);
        #1;
        sys_rst_n  = rst_v;
        start      = start_v;
        force_full = ff_v;
        @(negedge sys_clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitFor(input logic [2:0] st, input logic [15:0] pc, input int budget,
                           input string tag);
        logic reached;
        reached = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((state === st) && (pass_cnt === pc)) begin
                reached = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        checkOutput(tag, 32'(reached), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] reset and first session");
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_state",   32'(state),        32'd0);
        checkOutput("rst_busy",    32'(busy),         32'd0);
        checkOutput("rst_wr_en",   32'(fifo_wr_en),   32'd0);
        checkOutput("rst_rd_en",   32'(fifo_rd_en),   32'd0);
        checkOutput("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        checkOutput("rst_pass",    32'(pass_cnt),     32'd0);
        checkOutput("rst_err",     32'(err_cnt),      32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("idle_state",  32'(state),        32'd0);

        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s1_fill_state", 32'(state),        32'd1);
        checkOutput("s1_first_wr",   32'(fifo_wr_en),   32'd1);
        checkOutput("s1_first_data", 32'(fifo_wr_data), 32'h00);
        checkOutput("s1_busy",       32'(busy),         32'd1);

        waitFor(3'd2, 16'd0, 400, "s1_reach_f_settle");
        checkOutput("s1_fill_words", 32'(count),      32'd253);
        checkOutput("s1_settle_wr",  32'(fifo_wr_en), 32'd0);
        checkOutput("s1_settle_rd",  32'(fifo_rd_en), 32'd0);
        waitFor(3'd4, 16'd0, 400, "s1_reach_d_settle");
        checkOutput("s1_left_words", 32'(count), 32'd1);

        waitFor(3'd5, 16'd2, 1500, "s1_reach_done");
        checkOutput("s1_pass",     32'(pass_cnt),       32'd2);
        checkOutput("s1_err",      32'(err_cnt),        32'd0);
        checkOutput("s1_busy_end", 32'(busy),           32'd0);
        checkOutput("s1_wr_cnt",   32'(fifo_wr_data),   32'hF9);
        checkOutput("s1_overflow", 32'(overflow_seen),  32'd0);
        checkOutput("s1_underflw", 32'(underflow_seen), 32'd0);
        checkOutput("s1_wr_seq",   32'(wr_seq_err),     32'd0);

        $display("[TB] second session: corrupted read, forced full, start while busy");
        corrupt_idx = read_total + 10;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s2_fill_state", 32'(state),        32'd1);
        checkOutput("s2_first_data", 32'(fifo_wr_data), 32'hF9);
        checkOutput("s2_pass_clr",   32'(pass_cnt),     32'd0);
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("s2_full_wr_en", 32'(fifo_wr_en),   32'd0);
            checkOutput("s2_full_hold",  32'(fifo_wr_data), 32'h0E);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s2_resume_wr",   32'(fifo_wr_en),   32'd1);
        checkOutput("s2_resume_data", 32'(fifo_wr_data), 32'h0E);

        waitFor(3'd1, 16'd1, 1500, "s2_reach_fill2");
        checkOutput("s2_err_pass1", 32'(err_cnt), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s2_busy_start_state", 32'(state),    32'd1);
        checkOutput("s2_busy_start_pass",  32'(pass_cnt), 32'd1);
        checkOutput("s2_busy_start_err",   32'(err_cnt),  32'd1);

        waitFor(3'd5, 16'd2, 1500, "s2_reach_done");
        checkOutput("s2_pass",     32'(pass_cnt),       32'd2);
        checkOutput("s2_err",      32'(err_cnt),        32'd1);
        checkOutput("s2_wr_cnt",   32'(fifo_wr_data),   32'hF1);
        checkOutput("s2_overflow", 32'(overflow_seen),  32'd0);
        checkOutput("s2_underflw", 32'(underflow_seen), 32'd0);
        checkOutput("s2_both",     32'(both_seen),      32'd0);
        checkOutput("s2_wr_seq",   32'(wr_seq_err),     32'd0);

        $display("[TB] third session: reset mid-drain");
        corrupt_idx = -1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s3_err_clr", 32'(err_cnt), 32'd0);
        waitFor(3'd3, 16'd1, 1500, "s3_reach_drain2");
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s3_mid_rd_en", 32'(fifo_rd_en), 32'd1);
        checkOutput("s3_mid_pass",  32'(pass_cnt),   32'd1);
        checkOutput("s3_mid_err",   32'(err_cnt),    32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s3_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("s3_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s3_post_state", 32'(state),        32'd0);
        checkOutput("s3_post_pass",  32'(pass_cnt),     32'd0);
        checkOutput("s3_post_err",   32'(err_cnt),      32'd0);
        checkOutput("s3_post_busy",  32'(busy),         32'd0);
        checkOutput("s3_post_wdata", 32'(fifo_wr_data), 32'd0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s3_idle_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("s3_idle_state", 32'(state),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
